// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder, reused every cycle by serial_adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;

    full_adder_cell u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (c_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign accept = start && (state != RUN);
    assign last   = (cnt == LAST);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift-then-insert keeps WIDTH=1 legal without a zero-width slice.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            c_reg <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            c_reg  <= fa_carry;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum      <= res_next;
                carry    <= fa_carry;
                overflow <= c_reg ^ fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 scoreboard tests plus a WIDTH=1 exhaustive sweep.
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, carry, overflow;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic       sub1 = 1'b0;
    logic       cin1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, carry1, overflow1;
    logic [0:0] sum1;

    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(overflow1)
    );

    // Reference from plain integer arithmetic, independent of the carry-chain formulation.
    function automatic exp_t model8(input logic [7:0] ia, input logic [7:0] ib,
                                    input logic ic, input logic is);
        exp_t e;
        int   u;
        int   sv;
        if (!is) begin
            u   = int'(ia) + int'(ib) + int'(ic);
            e.c = (u > 255);
            sv  = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
        end else begin
            u   = int'(ia) - int'(ib) - int'(ic);
            e.c = (u >= 0);
            sv  = int'($signed(ia)) - int'($signed(ib)) - int'(ic);
        end
        e.s = u[7:0];
        e.v = (sv > 127) || (sv < -128);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        sb.push_back(model8(ia, ib, ic, is));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; counts busy cycles and negedges waited.
    task automatic wait_done(output int busy_cyc, output int waited, output bit seen);
        busy_cyc = 0; waited = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                waited = i;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, sum, carry, overflow} !== 12'h000)
            $display("FAIL reset_async: got busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                     busy, done, sum, carry, overflow);
        else passed++;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, sum, carry, overflow} !== 12'h000)
            $display("FAIL reset_idle: got busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                     busy, done, sum, carry, overflow);
        else passed++;
    endtask

    task automatic test_add_sub;
        logic [7:0] va[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [7:0] vb[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
        logic       vc[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int   bc, w;
        bit   seen;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue(va[k], vb[k], vc[k], vs[k]);
            wait_done(bc, w, seen);
            e = sb.pop_front();
            total++;
            if (!seen) begin
                $display("FAIL arith%0d_done: got no done within 40 cycles, want done", k);
                continue;
            end else passed++;
            total++;
            if (sum !== e.s) $display("FAIL arith%0d_sum: got %h want %h", k, sum, e.s);
            else passed++;
            total++;
            if (carry !== e.c) $display("FAIL arith%0d_carry: got %b want %b", k, carry, e.c);
            else passed++;
            total++;
            if (overflow !== e.v) $display("FAIL arith%0d_ovf: got %b want %b", k, overflow, e.v);
            else passed++;
            total++;
            if (bc != 8 || busy !== 1'b0)
                $display("FAIL arith%0d_busy: got %0d busy cycles (busy@done=%b), want 8 (0)", k, bc, busy);
            else passed++;
            @(negedge clk);
            total++;
            if (done !== 1'b0) $display("FAIL arith%0d_pulse: got done=%b one cycle later, want 0", k, done);
            else passed++;
        end
    endtask

    task automatic test_start_ignored;
        int   bc, w;
        bit   seen;
        bit   extra;
        exp_t e;
        @(negedge clk);
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, w, seen);
        e = sb.pop_front();
        total++;
        if (!seen || sum !== e.s || carry !== e.c)
            $display("FAIL ignore_result: got seen=%b sum=%h carry=%b, want 1 %h %b", seen, sum, carry, e.s, e.c);
        else passed++;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        total++;
        if (extra) $display("FAIL ignore_queued: got extra busy/done after result, want none");
        else passed++;
    endtask

    task automatic test_back_to_back;
        int   bc, w;
        bit   seen;
        exp_t e;
        @(negedge clk);
        issue(8'h01, 8'h02, 1'b1, 1'b0);
        wait_done(bc, w, seen);
        e = sb.pop_front();
        total++;
        if (!seen || sum !== e.s) $display("FAIL b2b_first: got seen=%b sum=%h, want 1 %h", seen, sum, e.s);
        else passed++;
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_no_idle: got busy=%b after DONE+start, want 1", busy);
        else passed++;
        wait_done(bc, w, seen);
        e = sb.pop_front();
        total++;
        if (!seen || w + 1 != 9) $display("FAIL b2b_spacing: got seen=%b spacing=%0d, want 1 9", seen, w + 1);
        else passed++;
        total++;
        if (sum !== e.s || carry !== e.c || overflow !== e.v)
            $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b", sum, carry, overflow, e.s, e.c, e.v);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        bit   got_done;
        exp_t e;
        @(negedge clk);
        issue(8'h33, 8'h44, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        e = sb.pop_back();
        total++;
        if ({busy, done, sum, carry, overflow} !== 12'h000)
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h carry=%b ovf=%b, want all 0",
                     busy, done, sum, carry, overflow);
        else passed++;
        @(negedge clk) rst = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        total++;
        if (got_done || sum !== 8'h00) $display("FAIL midrun_nodone: got done=%b sum=%h, want 0 00", got_done, sum);
        else passed++;
    endtask

    task automatic test_width1_sweep;
        logic [3:0] v;
        logic       bb, cc;
        logic [1:0] tot;
        bit         seen;
        int         bc;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            @(negedge clk);
            a1 = v[3]; b1 = v[2]; cin1 = v[1]; sub1 = v[0]; start1 = 1'b1;
            bb  = v[2] ^ v[0];
            cc  = v[1] ^ v[0];
            tot = 2'(v[3]) + 2'(bb) + 2'(cc);
            @(negedge clk);
            start1 = 1'b0;
            seen = 1'b0; bc = 0;
            for (int i = 0; i < 10; i++) begin
                if (done1) begin seen = 1'b1; break; end
                if (busy1) bc++;
                @(negedge clk);
            end
            total++;
            if (!seen || bc != 1) $display("FAIL w1_%0d_timing: got seen=%b busy=%0d, want 1 1", k, seen, bc);
            else passed++;
            total++;
            if (sum1 !== tot[0] || carry1 !== tot[1] || overflow1 !== (cc ^ tot[1]))
                $display("FAIL w1_%0d_result: got s=%b c=%b v=%b want s=%b c=%b v=%b",
                         k, sum1, carry1, overflow1, tot[0], tot[1], cc ^ tot[1]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_run;
        test_width1_sweep;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It computes `a + b + cin` or `a - b - cin` on WIDTH-bit operands, one bit per clock, LSB first, using a single reused full-adder cell. It uses a start/busy/done handshake and registered result, carry and overflow outputs. It is the sequential, width-generic successor to the lab's one-bit combinational full adder, and it is intended for area-minimal datapaths and as the arithmetic core of later lab sequencers.

## Interface
- `WIDTH`, default 8: operand and result width; legal range ≥ 1.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request an operation; sampled only when not busy.
- `sub`  in  1: 0 selects add (`a + b + cin`); 1 selects subtract (`a - b - cin`, with `cin` acting as borrow-in).
- `a`  in  WIDTH: operand A; captured on the accepting edge.
- `b`  in  WIDTH: operand B; captured on the accepting edge.
- `cin`  in  1: carry-in for add, borrow-in for subtract; captured on the accepting edge.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: single-cycle pulse when the result registers update.
- `sum`  out  WIDTH: result; holds its value until the next completion.
- `carry`  out  1: raw carry out of the MSB. In subtract mode, 1 means no borrow.
- `overflow`  out  1: two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- **States:**
  - IDLE: waiting for `start`.
  - RUN: processing bits.
  - DONE: one cycle with `done` high.
- **Accept.** In IDLE or DONE, `start=1` on an edge moves the block to RUN and latches:
  - `a` into the A shift register;
  - `b XOR {WIDTH{sub}}` into the B shift register;
  - the initial carry `cin XOR sub`;
  - bit counter = 0.
- **RUN, each edge:**
  - the full-adder cell adds A[0], B[0] and the carry register;
  - the sum bit shifts into the MSB of the result shift register;
  - the A and B shift registers shift right;
  - the carry register takes the cell's carry out;
  - the counter increments.
- **Last bit (counter = WIDTH-1):**
  - the carry register's value before the update (the carry into the MSB) is XORed with the cell's carry out and written to `overflow`;
  - the completed shift value is written to `sum`;
  - the cell's carry out is written to `carry`;
  - the state moves to DONE.
- **DONE:**
  - `done=1` for exactly one cycle;
  - without `start`, the next state is IDLE;
  - with `start`, the next state is RUN (back-to-back operation, no dead cycle).
- **Start while busy:** `start` in RUN is ignored and is not queued.
- **Output stability:** `sum`, `carry` and `overflow` change only on the completion edge and on reset. They never show partial results during RUN.
- **Mode arithmetic:** subtract is implemented as `a + ~b + (1 - cin)`, which equals `a - b - cin` mod 2^WIDTH.
- **WIDTH = 1:** RUN lasts one cycle; `overflow = cin_eff XOR carry`.

## Timing
- **Reset values:**
  - state IDLE;
  - `busy=0`, `done=0`;
  - `sum=0`, `carry=0`, `overflow=0`;
  - internal shift registers, carry register and counter all 0.
- **Reset mid-operation:** an asserted `rst` forces the reset values immediately, asynchronously. No `done` is produced for the aborted operation.
- **Latency:** call the accepting edge E0.
  - `busy` is high from E0 to E0+WIDTH.
  - The results and `done` appear after edge E0+WIDTH.
  - `done` falls at E0+WIDTH+1.
- **Throughput:** one operation per WIDTH+1 cycles when back-to-back.
- **`busy` and `done`:** `busy` is registered (state == RUN) and is never high in the same cycle as `done`.

## Structure
- **Package `serial_adder_pkg`:** state enum (IDLE, RUN, DONE).
- **Counter width:** use `$clog2(WIDTH)` with a minimum of 1.
- **Sub-module `full_adder_cell`:** combinational; inputs `a`, `b`, `cin`; outputs `sum`, `carry`. Instantiated once.
- **Top level:** the FSM, counter, shift registers and output registers are kept in the top module.

## Test plan
All cases use WIDTH=8 unless noted.
- **Reset:** assert `rst` asynchronously between edges → every output reads 0 immediately. Release and hold `start=0` → outputs remain 0 and state remains IDLE.
- **Add with signed overflow:** `a=8'h5A`, `b=8'h3C`, `cin=1`, `sub=0` → `busy` high for 8 cycles; `done` pulses one cycle; `sum=8'h97`, `carry=0`, `overflow=1`.
- **Add with wrap:** `a=8'hFF`, `b=8'h01`, `cin=0`, `sub=0` → `sum=8'h00`, `carry=1`, `overflow=0`.
- **Subtract:**
  - `a=8'h10`, `b=8'h20`, `cin=0`, `sub=1` → `sum=8'hF0`, `carry=0` (borrow), `overflow=0`.
  - `a=8'h80`, `b=8'h01`, `sub=1`, `cin=0` → `sum=8'h7F`, `carry=1`, `overflow=1`.
- **Handshake:**
  - `start` pulsed at cycle 3 of RUN → ignored; the result is that of the first operation.
  - `start` held during the DONE cycle → a new RUN begins with no IDLE cycle, and `done` pulses again exactly 9 cycles later.
- **Reset mid-run and WIDTH=1 sweep:**
  - `rst` asserted after 4 bits → no `done`; `sum=0`, `carry=0`, `overflow=0`.
  - With WIDTH=1, drive all 16 combinations of `a`, `b`, `cin`, `sub` → `sum`/`carry` match the one-bit full-adder truth table, with `b` and `cin` inverted when `sub=1`.
